// File: rtl/alu_issue_ctrl_if.sv
// Handshake and result bundle between the instruction source and the ALU issue controller.
// The controller side uses the slave modport; the source/observer side uses master.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] instr_in;
    logic             instr_valid;
    logic             instr_ready;
    logic             flush;
    logic             hold;
    logic             iss_valid;
    logic [6:0]       iss_opcode;
    logic [4:0]       iss_rd;
    logic [2:0]       iss_funct3;
    logic [4:0]       iss_rs1;
    logic [4:0]       iss_rs2;
    logic [6:0]       iss_funct7;
    logic             wb_en;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] busy_vec;
    logic [15:0]      stall_cnt;

    modport master (
        output instr_in, instr_valid, flush, hold,
        input  instr_ready, iss_valid, iss_opcode, iss_rd, iss_funct3, iss_rs1,
               iss_rs2, iss_funct7, wb_en, wb_rd, busy_vec, stall_cnt
    );

    modport slave (
        input  instr_in, instr_valid, flush, hold,
        output instr_ready, iss_valid, iss_opcode, iss_rd, iss_funct3, iss_rs1,
               iss_rs2, iss_funct7, wb_en, wb_rd, busy_vec, stall_cnt
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// In-order single-ALU issue controller: instruction FIFO, RV32 field decode,
// busy-bit scoreboard for RAW/WAW stalls, and a fixed-latency writeback strobe pipe.
module alu_issue_ctrl #(
    parameter int WIDTH      = 32,
    parameter int ALU_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;

    logic             iss_valid_r;
    logic [6:0]       iss_opcode_r;
    logic [4:0]       iss_rd_r;
    logic [2:0]       iss_funct3_r;
    logic [4:0]       iss_rs1_r;
    logic [4:0]       iss_rs2_r;
    logic [6:0]       iss_funct7_r;

    logic [ALU_LAT-1:0] wb_v_r;
    logic [4:0]         wb_rd_r [ALU_LAT];
    logic [WIDTH-1:0]   busy_r;
    logic [15:0]        stall_cnt_r;

    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             issue_s;
    logic             hazard_s;
    logic             stall_s;
    logic [WIDTH-1:0] head_s;
    logic [4:0]       head_rd_s;
    logic [4:0]       head_rs1_s;
    logic [4:0]       head_rs2_s;
    logic             wb_en_s;
    logic [4:0]       wb_rd_s;
    logic [WIDTH-1:0] set_mask_s;
    logic [WIDTH-1:0] clr_mask_s;
    logic [WIDTH-1:0] busy_next_s;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

    assign head_s     = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
    assign head_rd_s  = head_s[11:7];
    assign head_rs1_s = head_s[19:15];
    assign head_rs2_s = head_s[24:20];

    // x0 can never be marked busy, so it never creates a hazard here.
    assign hazard_s = busy_r[head_rs1_s] | busy_r[head_rs2_s] | busy_r[head_rd_s];
    assign stall_s  = !empty_s && !bus.hold && !bus.flush && hazard_s;
    assign issue_s  = !empty_s && !bus.hold && !bus.flush && !hazard_s;
    assign push_s   = bus.instr_valid && !full_s && !bus.flush;

    assign wb_en_s = wb_v_r[ALU_LAT-1];
    assign wb_rd_s = wb_rd_r[ALU_LAT-1];

    assign set_mask_s  = (issue_s && (head_rd_s != 5'd0)) ?
                         ({{(WIDTH-1){1'b0}}, 1'b1} << head_rd_s) : {WIDTH{1'b0}};
    assign clr_mask_s  = wb_en_s ?
                         ({{(WIDTH-1){1'b0}}, 1'b1} << wb_rd_s) : {WIDTH{1'b0}};
    assign busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;

    // FIFO storage write; contents need no reset since pointers qualify them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= bus.instr_in;
        end
    end

    // FIFO pointers; flush drops every buffered entry and any same-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else if (bus.flush) begin
            rd_ptr_r <= wr_ptr_r;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Issue register: decoded fields update only on issue and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_r  <= 1'b0;
            iss_opcode_r <= 7'd0;
            iss_rd_r     <= 5'd0;
            iss_funct3_r <= 3'd0;
            iss_rs1_r    <= 5'd0;
            iss_rs2_r    <= 5'd0;
            iss_funct7_r <= 7'd0;
        end else begin
            iss_valid_r <= issue_s;
            if (issue_s) begin
                iss_opcode_r <= head_s[6:0];
                iss_rd_r     <= head_s[11:7];
                iss_funct3_r <= head_s[14:12];
                iss_rs1_r    <= head_s[19:15];
                iss_rs2_r    <= head_s[24:20];
                iss_funct7_r <= head_s[31:25];
            end
        end
    end

    // Writeback pipe fed from the issue register so wb_en trails iss_valid by ALU_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_v_r <= {ALU_LAT{1'b0}};
            for (int k = 0; k < ALU_LAT; k++) begin
                wb_rd_r[k] <= 5'd0;
            end
        end else begin
            wb_v_r[0]  <= iss_valid_r;
            wb_rd_r[0] <= iss_valid_r ? iss_rd_r : 5'd0;
            for (int k = 1; k < ALU_LAT; k++) begin
                wb_v_r[k]  <= wb_v_r[k-1];
                wb_rd_r[k] <= wb_rd_r[k-1];
            end
        end
    end

    // Scoreboard and saturating hazard-stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r      <= {WIDTH{1'b0}};
            stall_cnt_r <= 16'd0;
        end else begin
            busy_r <= busy_next_s;
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign bus.instr_ready = !full_s;
    assign bus.iss_valid   = iss_valid_r;
    assign bus.iss_opcode  = iss_opcode_r;
    assign bus.iss_rd      = iss_rd_r;
    assign bus.iss_funct3  = iss_funct3_r;
    assign bus.iss_rs1     = iss_rs1_r;
    assign bus.iss_rs2     = iss_rs2_r;
    assign bus.iss_funct7  = iss_funct7_r;
    assign bus.wb_en       = wb_en_s;
    assign bus.wb_rd       = wb_rd_s;
    assign bus.busy_vec    = busy_r;
    assign bus.stall_cnt   = stall_cnt_r;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed-vector bench for alu_issue_ctrl (ALU_LAT=2, FIFO_DEPTH=4) with hand-computed expectations.
module tb_alu_issue_ctrl;
    logic clk;
    logic rst;
    int   checks_n;
    int   failures_n;

    alu_issue_ctrl_if #(.WIDTH(32)) bus ();

    alu_issue_ctrl #(
        .WIDTH      (32),
        .ALU_LAT    (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_n++;
        if (act !== exp) begin
            failures_n++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w [5];
        checks_n   = 0;
        failures_n = 0;
        rst             = 1'b1;
        bus.instr_in    = 32'd0;
        bus.instr_valid = 1'b0;
        bus.flush       = 1'b0;
        bus.hold        = 1'b0;
        tick();
        tick();
        check("rst_iss_valid", {31'd0, bus.iss_valid}, 32'd0);
        check("rst_iss_rd",    {27'd0, bus.iss_rd}, 32'd0);
        check("rst_wb_en",     {31'd0, bus.wb_en}, 32'd0);
        check("rst_wb_rd",     {27'd0, bus.wb_rd}, 32'd0);
        check("rst_busy",      bus.busy_vec, 32'd0);
        check("rst_stall",     {16'd0, bus.stall_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);

        // Two independent ops issue on consecutive cycles; wb two cycles after each.
        bus.instr_in = 32'h0020_8033; bus.instr_valid = 1'b1;
        tick();
        bus.instr_in = 32'h0052_01B3;
        tick();
        bus.instr_valid = 1'b0;
        check("t1_iss0_valid", {31'd0, bus.iss_valid}, 32'd1);
        check("t1_iss0_rd",    {27'd0, bus.iss_rd}, 32'd0);
        check("t1_iss0_rs1",   {27'd0, bus.iss_rs1}, 32'd1);
        check("t1_iss0_rs2",   {27'd0, bus.iss_rs2}, 32'd2);
        check("t1_iss0_op",    {25'd0, bus.iss_opcode}, 32'h33);
        tick();
        check("t1_iss1_valid", {31'd0, bus.iss_valid}, 32'd1);
        check("t1_iss1_rd",    {27'd0, bus.iss_rd}, 32'd3);
        check("t1_iss1_rs1",   {27'd0, bus.iss_rs1}, 32'd4);
        check("t1_iss1_rs2",   {27'd0, bus.iss_rs2}, 32'd5);
        check("t1_busy3",      bus.busy_vec, 32'h0000_0008);
        tick();
        check("t1_wb0_en",  {31'd0, bus.wb_en}, 32'd1);
        check("t1_wb0_rd",  {27'd0, bus.wb_rd}, 32'd0);
        check("t1_idle",    {31'd0, bus.iss_valid}, 32'd0);
        tick();
        check("t1_wb1_en",  {31'd0, bus.wb_en}, 32'd1);
        check("t1_wb1_rd",  {27'd0, bus.wb_rd}, 32'd3);
        tick();
        check("t1_wb_done", {31'd0, bus.wb_en}, 32'd0);
        check("t1_busy0",   bus.busy_vec, 32'd0);

        // rd=x0 op never blocks a following addi x1.
        bus.instr_in = 32'h0020_8033; bus.instr_valid = 1'b1;
        tick();
        bus.instr_in = 32'h0010_0093;
        tick();
        bus.instr_valid = 1'b0;
        check("t2_iss0_valid", {31'd0, bus.iss_valid}, 32'd1);
        check("t2_iss0_rd",    {27'd0, bus.iss_rd}, 32'd0);
        tick();
        check("t2_iss1_valid", {31'd0, bus.iss_valid}, 32'd1);
        check("t2_iss1_rd",    {27'd0, bus.iss_rd}, 32'd1);
        check("t2_iss1_op",    {25'd0, bus.iss_opcode}, 32'h13);
        repeat (4) tick();
        check("t2_busy0", bus.busy_vec, 32'd0);

        // RAW on x5: dependent add waits for the cycle after wb_en, two stall cycles.
        bus.instr_in = 32'h0010_0293; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        check("t3_addi_valid", {31'd0, bus.iss_valid}, 32'd1);
        check("t3_addi_rd",    {27'd0, bus.iss_rd}, 32'd5);
        bus.instr_in = 32'h0052_8333; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("t3_stall_a",  {31'd0, bus.iss_valid}, 32'd0);
        check("t3_busy5",    bus.busy_vec, 32'h0000_0020);
        tick();
        check("t3_wb_en",    {31'd0, bus.wb_en}, 32'd1);
        check("t3_wb_rd",    {27'd0, bus.wb_rd}, 32'd5);
        check("t3_stall_b",  {31'd0, bus.iss_valid}, 32'd0);
        check("t3_cnt1",     {16'd0, bus.stall_cnt}, 32'd1);
        tick();
        check("t3_stall_c",  {31'd0, bus.iss_valid}, 32'd0);
        check("t3_busy_clr", bus.busy_vec, 32'd0);
        check("t3_cnt2",     {16'd0, bus.stall_cnt}, 32'd2);
        tick();
        check("t3_add_valid", {31'd0, bus.iss_valid}, 32'd1);
        check("t3_add_rd",    {27'd0, bus.iss_rd}, 32'd6);
        check("t3_add_rs1",   {27'd0, bus.iss_rs1}, 32'd5);
        check("t3_busy6",     bus.busy_vec, 32'h0000_0040);
        check("t3_cnt_hold",  {16'd0, bus.stall_cnt}, 32'd2);
        repeat (3) tick();
        check("t3_busy0", bus.busy_vec, 32'd0);

        // Fill under hold: ready drops after four, fifth waits and all five issue in order.
        for (int i = 0; i < 5; i++) begin
            w[i] = 32'h0000_0033 | ((32'd7 + 32'(i)) << 7);
        end
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.instr_in = w[i]; bus.instr_valid = 1'b1;
            tick();
            if (i == 2) begin
                check("t4_ready_3", {31'd0, bus.instr_ready}, 32'd1);
            end
        end
        check("t4_ready_full", {31'd0, bus.instr_ready}, 32'd0);
        check("t4_no_issue",   {31'd0, bus.iss_valid}, 32'd0);
        bus.instr_in = w[4];
        bus.hold     = 1'b0;
        tick();
        check("t4_iss0_valid", {31'd0, bus.iss_valid}, 32'd1);
        check("t4_iss0_rd",    {27'd0, bus.iss_rd}, 32'd7);
        check("t4_ready_again", {31'd0, bus.instr_ready}, 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        check("t4_iss1_rd", {27'd0, bus.iss_rd}, 32'd8);
        for (int k = 2; k < 5; k++) begin
            tick();
            check("t4_issk_valid", {31'd0, bus.iss_valid}, 32'd1);
            check("t4_issk_rd",    {27'd0, bus.iss_rd}, 32'd7 + 32'(k));
        end
        repeat (3) tick();
        check("t4_busy0", bus.busy_vec, 32'd0);
        check("t4_cnt",   {16'd0, bus.stall_cnt}, 32'd2);

        // Flush with three buffered and one in flight; push during flush is discarded.
        w[0] = 32'h0000_0033 | (32'd12 << 7);
        for (int i = 1; i < 4; i++) begin
            w[i] = 32'h0000_0033 | (32'd12 << 15) | ((32'd12 + 32'(i)) << 7);
        end
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.instr_in = w[i]; bus.instr_valid = 1'b1;
            tick();
        end
        check("t5_full", {31'd0, bus.instr_ready}, 32'd0);
        bus.instr_valid = 1'b0;
        bus.hold        = 1'b0;
        tick();
        check("t5_iss_valid", {31'd0, bus.iss_valid}, 32'd1);
        check("t5_iss_rd",    {27'd0, bus.iss_rd}, 32'd12);
        check("t5_busy12",    bus.busy_vec, 32'h0000_1000);
        bus.flush       = 1'b1;
        bus.instr_in    = 32'h0000_0033 | (32'd16 << 7);
        bus.instr_valid = 1'b1;
        tick();
        bus.flush       = 1'b0;
        bus.instr_valid = 1'b0;
        check("t5_no_iss_a", {31'd0, bus.iss_valid}, 32'd0);
        check("t5_ready",    {31'd0, bus.instr_ready}, 32'd1);
        tick();
        check("t5_wb_en",    {31'd0, bus.wb_en}, 32'd1);
        check("t5_wb_rd",    {27'd0, bus.wb_rd}, 32'd12);
        check("t5_no_iss_b", {31'd0, bus.iss_valid}, 32'd0);
        tick();
        check("t5_no_iss_c", {31'd0, bus.iss_valid}, 32'd0);
        check("t5_busy0",    bus.busy_vec, 32'd0);
        check("t5_cnt",      {16'd0, bus.stall_cnt}, 32'd2);

        // Reset with two writebacks in flight cancels them.
        bus.instr_in = 32'h0000_0033 | (32'd17 << 7); bus.instr_valid = 1'b1;
        tick();
        bus.instr_in = 32'h0000_0033 | (32'd18 << 7);
        tick();
        bus.instr_valid = 1'b0;
        check("t6_iss_rd17", {27'd0, bus.iss_rd}, 32'd17);
        tick();
        check("t6_busy2", bus.busy_vec, 32'h0006_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_wb_en",    {31'd0, bus.wb_en}, 32'd0);
        check("t6_busy0",    bus.busy_vec, 32'd0);
        check("t6_ready",    {31'd0, bus.instr_ready}, 32'd1);
        check("t6_iss_valid", {31'd0, bus.iss_valid}, 32'd0);
        check("t6_cnt0",     {16'd0, bus.stall_cnt}, 32'd0);
        tick();
        check("t6_wb_cancel_a", {31'd0, bus.wb_en}, 32'd0);
        tick();
        check("t6_wb_cancel_b", {31'd0, bus.wb_en}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
        $finish;
    end
endmodule
